h80clk_ctrl: RTL and testbench

Parametrised CPU clock controller for the h80 system: turns the free-running `sysclk` into the CPU bus clock `cpu_clk`, with free-running (autorun) and single-step modes. A debounced push-button selects the mode: a short press issues one step, a long press toggles autorun. The block replaces ad-hoc divider and button logic in board tops and drives `h80cpu`, `h80cpu_mem` and `h80cpu_io` through `cpu_clk` and its inverse. The autorun rate is selectable at run time.

---
 rtl/h80clk_pkg.sv | 18 +
 rtl/h80clk_debounce.sv | 99 +++++++++
 rtl/h80clk_ctrl.sv | 128 ++++++++++++
 tb/tb_h80clk_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/h80clk_pkg.sv
// Shared types and constants for the h80 CPU clock controller.
package h80clk_pkg;

  typedef enum logic [1:0] {
    S_RELEASED = 2'd0,
    S_PRESSED  = 2'd1,
    S_LONG     = 2'd2
  } btn_state_t;

  localparam int H80CLK_MAX_RATE = 23;
  localparam int H80CLK_CYCLES_W = 32;

  // Number of sample ticks covering a duration in ms at a tick rate in Hz.
  function automatic int h80clk_ticks(input int ms, input int hz);
    return (ms * hz) / 1000;
  endfunction

endpackage

// File: rtl/h80clk_debounce.sv
// Button synchroniser, debounce sample-tick generator and press classifier.
// Emits one-cycle short_press / long_press pulses and the debounced level.
module h80clk_debounce
  import h80clk_pkg::*;
#(
  parameter int TICK_DIV = 2,
  parameter int DB_TICKS = 1,
  parameter int LP_TICKS = 1
) (
  input  logic sysclk,
  input  logic reset,
  input  logic btn,
  output logic btn_state,
  output logic short_press,
  output logic long_press
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DB_TICKS + 1);
  localparam int LW = $clog2(LP_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_TICKS - 1);
  localparam logic [LW-1:0] LP_LAST   = LW'(LP_TICKS - 1);

  logic [1:0]    sync_r;
  logic [TW-1:0] tick_cnt_r;
  logic [DW-1:0] db_cnt_r;
  logic [LW-1:0] hold_cnt_r;
  btn_state_t    state_r;

  logic btn_s;
  logic tick_s;
  logic db_hit_s;
  logic db_done_s;
  logic long_hit_s;

  // Decode tick and the debounce/hold terminal conditions.
  always_comb begin
    btn_s      = sync_r[1];
    tick_s     = (tick_cnt_r == TICK_LAST);
    // Released counts a stable high level; the other states count a stable low.
    db_hit_s   = (btn_s == (state_r == S_RELEASED));
    db_done_s  = tick_s && db_hit_s && (db_cnt_r == DB_LAST);
    long_hit_s = tick_s && (state_r == S_PRESSED) && (hold_cnt_r == LP_LAST);
    long_press  = long_hit_s;
    short_press = db_done_s && (state_r == S_PRESSED) && !long_hit_s;
  end

  // Synchroniser, tick divider and button FSM state.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_r     <= 2'b00;
      tick_cnt_r <= '0;
      db_cnt_r   <= '0;
      hold_cnt_r <= '0;
      state_r    <= S_RELEASED;
      btn_state  <= 1'b0;
    end else begin
      sync_r     <= {sync_r[0], btn};
      tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TW'(1);
      if (tick_s) begin
        if (db_hit_s && !db_done_s) begin
          db_cnt_r <= db_cnt_r + DW'(1);
        end else begin
          db_cnt_r <= '0;
        end
        case (state_r)
          S_RELEASED: begin
            if (db_done_s) begin
              state_r    <= S_PRESSED;
              btn_state  <= 1'b1;
              hold_cnt_r <= '0;
            end
          end
          S_PRESSED: begin
            hold_cnt_r <= hold_cnt_r + LW'(1);
            if (long_hit_s) begin
              state_r <= S_LONG;
            end else if (db_done_s) begin
              state_r   <= S_RELEASED;
              btn_state <= 1'b0;
            end
          end
          S_LONG: begin
            if (db_done_s) begin
              state_r   <= S_RELEASED;
              btn_state <= 1'b0;
            end
          end
          default: begin
            state_r   <= S_RELEASED;
            btn_state <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/h80clk_ctrl.sv
// h80 CPU clock controller: autorun / single-step cpu_clk generation.
// Optional macro H80CLK_CYCLE_COUNT_EN adds the 32-bit rising-edge counter.
module h80clk_ctrl
  import h80clk_pkg::*;
#(
  parameter int   SYSCLK_FREQ   = 27000000,
  parameter int   TICK_HZ       = 1000,
  parameter int   DEBOUNCE_MS   = 20,
  parameter int   LONGPRESS_MS  = 2000,
  parameter int   RATE_WIDTH    = 5,
  parameter logic RESET_AUTORUN = 1'b1
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  btn,
  input  logic [RATE_WIDTH-1:0] rate_sel,
  input  logic                  halt,
  output logic                  cpu_clk,
  output logic                  cpu_clk_rise,
  output logic                  autorun,
  output logic                  btn_state
`ifdef H80CLK_CYCLE_COUNT_EN
  ,
  output logic [H80CLK_CYCLES_W-1:0] cycles
`endif
);

  localparam int TICK_DIV_RAW = SYSCLK_FREQ / TICK_HZ;
  localparam int TICK_DIV     = (TICK_DIV_RAW < 2) ? 2 : TICK_DIV_RAW;
  localparam int DB_RAW       = h80clk_ticks(DEBOUNCE_MS, TICK_HZ);
  localparam int DB_TICKS     = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int LP_RAW       = h80clk_ticks(LONGPRESS_MS, TICK_HZ);
  localparam int LP_TICKS     = (LP_RAW < 1) ? 1 : LP_RAW;
  localparam int HC_W         = H80CLK_MAX_RATE + 1;

  logic            short_press_s;
  logic            long_press_s;
  logic [4:0]      rate_r;
  logic [HC_W-1:0] hc_r;
  logic [4:0]      rate_clamp_s;
  logic [HC_W-1:0] term_s;
  logic            hc_last_s;
  logic            run_s;
  logic            step_s;

  h80clk_debounce #(
    .TICK_DIV (TICK_DIV),
    .DB_TICKS (DB_TICKS),
    .LP_TICKS (LP_TICKS)
  ) u_debounce (
    .sysclk      (sysclk),
    .reset       (reset),
    .btn         (btn),
    .btn_state   (btn_state),
    .short_press (short_press_s),
    .long_press  (long_press_s)
  );

  // Rate clamp, half-period terminal count and run/step qualifiers.
  always_comb begin
    if (int'(rate_sel) > H80CLK_MAX_RATE) begin
      rate_clamp_s = 5'(H80CLK_MAX_RATE);
    end else begin
      rate_clamp_s = 5'(rate_sel);
    end
    term_s    = (HC_W'(1) << rate_r) - HC_W'(1);
    hc_last_s = (hc_r == term_s);
    run_s     = autorun && !halt;
    step_s    = short_press_s && !autorun && !halt;
  end

  // Mode register and phase generator; a started high phase always runs to term.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cpu_clk      <= 1'b0;
      cpu_clk_rise <= 1'b0;
      autorun      <= RESET_AUTORUN;
      hc_r         <= '0;
      rate_r       <= rate_clamp_s;
    end else begin
      cpu_clk_rise <= 1'b0;
      if (long_press_s) begin
        autorun <= !autorun;
      end
      if (cpu_clk) begin
        if (hc_last_s) begin
          cpu_clk <= 1'b0;
          hc_r    <= '0;
          rate_r  <= rate_clamp_s;
        end else begin
          hc_r <= hc_r + HC_W'(1);
        end
      end else if (run_s) begin
        if (hc_last_s) begin
          cpu_clk      <= 1'b1;
          cpu_clk_rise <= 1'b1;
          hc_r         <= '0;
          rate_r       <= rate_clamp_s;
        end else begin
          hc_r <= hc_r + HC_W'(1);
        end
      end else if (step_s) begin
        cpu_clk      <= 1'b1;
        cpu_clk_rise <= 1'b1;
        hc_r         <= '0;
        rate_r       <= rate_clamp_s;
      end else begin
        // Stopped while low: hold the counter idle so a resume restarts from 0.
        hc_r   <= '0;
        rate_r <= rate_clamp_s;
      end
    end
  end

`ifdef H80CLK_CYCLE_COUNT_EN
  // Count cpu_clk rising edges, wrapping naturally at 2^32.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cycles <= '0;
    end else if (cpu_clk_rise) begin
      cycles <= cycles + H80CLK_CYCLES_W'(1);
    end else begin
      cycles <= cycles;
    end
  end
`endif

endmodule

// File: tb/tb_h80clk_ctrl.sv
// Directed self-checking bench for h80clk_ctrl (tick every 10 cycles, DB=3, LP=20).
module tb_h80clk_ctrl;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       btn;
  logic       halt;
  logic [4:0] rate_sel;
  logic       cpu_clk;
  logic       cpu_clk_rise;
  logic       autorun;
  logic       btn_state;
`ifdef H80CLK_CYCLE_COUNT_EN
  logic [31:0] cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sysclk = ~sysclk;

  h80clk_ctrl #(
    .SYSCLK_FREQ   (1000),
    .TICK_HZ       (100),
    .DEBOUNCE_MS   (30),
    .LONGPRESS_MS  (200),
    .RATE_WIDTH    (5),
    .RESET_AUTORUN (1'b1)
  ) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .btn          (btn),
    .rate_sel     (rate_sel),
    .halt         (halt),
    .cpu_clk      (cpu_clk),
    .cpu_clk_rise (cpu_clk_rise),
    .autorun      (autorun),
    .btn_state    (btn_state)
`ifdef H80CLK_CYCLE_COUNT_EN
    ,
    .cycles       (cycles)
`endif
  );

  task automatic step_n(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn = 1'b0; halt = 1'b0; rate_sel = 5'd2;
    step_n(3);
    n_cmp++; if (cpu_clk !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_clk got %b want 0", cpu_clk); end
    n_cmp++; if (cpu_clk_rise !== 1'b0) begin n_bad++; $display("FAIL reset_rise got %b want 0", cpu_clk_rise); end
    n_cmp++; if (btn_state !== 1'b0) begin n_bad++; $display("FAIL reset_btn_state got %b want 0", btn_state); end
    n_cmp++; if (autorun !== 1'b1) begin n_bad++; $display("FAIL reset_autorun got %b want 1", autorun); end
`ifdef H80CLK_CYCLE_COUNT_EN
    n_cmp++; if (cycles !== 32'd0) begin n_bad++; $display("FAIL reset_cycles got %0d want 0", cycles); end
`endif
  endtask

  task automatic test_autorun_rate();
    logic exp_clk, exp_rise;
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step_n(1);
      exp_clk  = (k >= 4) && (((k - 4) % 8) < 4);
      exp_rise = (k >= 4) && (((k - 4) % 8) == 0);
      n_cmp++; if (cpu_clk !== exp_clk) begin n_bad++; $display("FAIL rate_clk cyc %0d got %b want %b", k, cpu_clk, exp_clk); end
      n_cmp++; if (cpu_clk_rise !== exp_rise) begin n_bad++; $display("FAIL rate_rise cyc %0d got %b want %b", k, cpu_clk_rise, exp_rise); end
    end
`ifdef H80CLK_CYCLE_COUNT_EN
    n_cmp++; if (cycles !== 32'd4) begin n_bad++; $display("FAIL rate_cycles got %0d want 4", cycles); end
`endif
  endtask

  task automatic test_glitch();
    logic seen_state = 1'b0;
    logic seen_short = 1'b0;
    btn = 1'b1;
    for (int i = 0; i < 75; i++) begin
      if (i == 15) btn = 1'b0;
      step_n(1);
      seen_state |= btn_state;
      seen_short |= dut.short_press_s;
    end
    n_cmp++; if (seen_state !== 1'b0) begin n_bad++; $display("FAIL glitch_btn_state got %b want 0", seen_state); end
    n_cmp++; if (seen_short !== 1'b0) begin n_bad++; $display("FAIL glitch_short got %b want 0", seen_short); end
    n_cmp++; if (autorun !== 1'b1) begin n_bad++; $display("FAIL glitch_autorun got %b want 1", autorun); end
  endtask

  task automatic test_long_press();
    int toggles = 0, bad_phase = 0, late_hi = 0, hi_len = 0;
    logic armed = 1'b0, stopped = 1'b0, prev_ar;
    logic held_state;
    btn = 1'b1;
    prev_ar = autorun;
    for (int i = 0; i < 2600; i++) begin
      if (i == 2500) begin held_state = btn_state; btn = 1'b0; end
      step_n(1);
      if (autorun !== prev_ar) toggles++;
      prev_ar = autorun;
      if (!cpu_clk) begin
        if (armed && hi_len > 0 && hi_len != 4) bad_phase++;
        armed = 1'b1; hi_len = 0;
        if (!autorun) stopped = 1'b1;
      end else begin
        if (armed) hi_len++;
        if (stopped) late_hi++;
      end
    end
    n_cmp++; if (toggles !== 1) begin n_bad++; $display("FAIL long_toggles got %0d want 1", toggles); end
    n_cmp++; if (autorun !== 1'b0) begin n_bad++; $display("FAIL long_autorun got %b want 0", autorun); end
    n_cmp++; if (bad_phase !== 0) begin n_bad++; $display("FAIL long_phase_len got %0d short phases want 0", bad_phase); end
    n_cmp++; if (late_hi !== 0) begin n_bad++; $display("FAIL long_stop got %0d high cycles after stop want 0", late_hi); end
    n_cmp++; if (held_state !== 1'b1) begin n_bad++; $display("FAIL long_held_state got %b want 1", held_state); end
    n_cmp++; if (btn_state !== 1'b0) begin n_bad++; $display("FAIL long_release_state got %b want 0", btn_state); end
  endtask

  task automatic test_single_step();
    int rises = 0, highs = 0;
`ifdef H80CLK_CYCLE_COUNT_EN
    logic [31:0] c0 = cycles;
`endif
    rate_sel = 5'd0;
    btn = 1'b1;
    step_n(50);
    btn = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step_n(1);
      if (cpu_clk_rise) rises++;
      if (cpu_clk) highs++;
    end
    n_cmp++; if (rises !== 1) begin n_bad++; $display("FAIL step_rises got %0d want 1", rises); end
    n_cmp++; if (highs !== 1) begin n_bad++; $display("FAIL step_high_cycles got %0d want 1", highs); end
`ifdef H80CLK_CYCLE_COUNT_EN
    n_cmp++; if (cycles !== c0 + 32'd1) begin n_bad++; $display("FAIL step_cycles got %0d want %0d", cycles, c0 + 32'd1); end
`endif
  endtask

  task automatic test_halt_mid_phase();
    logic found = 1'b0;
    int hi_while_halted = 0;
    rate_sel = 5'd3;
    btn = 1'b1; step_n(300); btn = 1'b0; step_n(60);
    n_cmp++; if (autorun !== 1'b1) begin n_bad++; $display("FAIL halt_autorun_back got %b want 1", autorun); end
    for (int i = 0; i < 40 && !found; i++) begin
      step_n(1);
      if (cpu_clk_rise) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL halt_wait_rise got %b want 1 (timeout)", found); end
    step_n(1);
    halt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_n(1);
      n_cmp++; if (cpu_clk !== 1'b1) begin n_bad++; $display("FAIL halt_hold_high idx %0d got %b want 1", i, cpu_clk); end
    end
    step_n(1);
    n_cmp++; if (cpu_clk !== 1'b0) begin n_bad++; $display("FAIL halt_end_low got %b want 0", cpu_clk); end
    for (int i = 0; i < 20; i++) begin
      step_n(1);
      if (cpu_clk) hi_while_halted++;
    end
    n_cmp++; if (hi_while_halted !== 0) begin n_bad++; $display("FAIL halt_stays_low got %0d want 0", hi_while_halted); end
    halt = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step_n(1);
      n_cmp++; if (cpu_clk !== 1'b0) begin n_bad++; $display("FAIL resume_low cyc %0d got %b want 0", k, cpu_clk); end
    end
    step_n(1);
    n_cmp++; if (cpu_clk !== 1'b1) begin n_bad++; $display("FAIL resume_rise_clk got %b want 1", cpu_clk); end
    n_cmp++; if (cpu_clk_rise !== 1'b1) begin n_bad++; $display("FAIL resume_rise_pulse got %b want 1", cpu_clk_rise); end
  endtask

  task automatic test_reset_mid_press();
    logic pressed = 1'b0;
    btn = 1'b1; step_n(300); btn = 1'b0; step_n(60);
    n_cmp++; if (autorun !== 1'b0) begin n_bad++; $display("FAIL rmp_autorun_off got %b want 0", autorun); end
    btn = 1'b1;
    for (int i = 0; i < 100 && !pressed; i++) begin
      step_n(1);
      if (btn_state) pressed = 1'b1;
    end
    n_cmp++; if (pressed !== 1'b1) begin n_bad++; $display("FAIL rmp_press got %b want 1 (timeout)", pressed); end
    step_n(2);
    reset = 1'b1;
    step_n(2);
    n_cmp++; if (cpu_clk !== 1'b0) begin n_bad++; $display("FAIL rmp_cpu_clk got %b want 0", cpu_clk); end
    n_cmp++; if (cpu_clk_rise !== 1'b0) begin n_bad++; $display("FAIL rmp_rise got %b want 0", cpu_clk_rise); end
    n_cmp++; if (btn_state !== 1'b0) begin n_bad++; $display("FAIL rmp_btn_state got %b want 0", btn_state); end
    n_cmp++; if (autorun !== 1'b1) begin n_bad++; $display("FAIL rmp_autorun got %b want 1", autorun); end
`ifdef H80CLK_CYCLE_COUNT_EN
    n_cmp++; if (cycles !== 32'd0) begin n_bad++; $display("FAIL rmp_cycles got %0d want 0", cycles); end
`endif
    reset = 1'b0;
    step_n(29);
    n_cmp++; if (btn_state !== 1'b0) begin n_bad++; $display("FAIL rmp_redebounce_early got %b want 0", btn_state); end
    step_n(1);
    n_cmp++; if (btn_state !== 1'b1) begin n_bad++; $display("FAIL rmp_redebounce got %b want 1", btn_state); end
    btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_autorun_rate();
    test_glitch();
    test_long_press();
    test_single_step();
    test_halt_mid_phase();
    test_reset_mid_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
